day_entry: RTL

- User-input front end that writes a new day value into the 1-99 day counter; it is the input-side counterpart of the counter's HEX display path.
- Conditions one raw active-low pushbutton: 2-FF synchronise, debounce, then classify each press as short or long.
- A small FSM takes two BCD digits from the switches (tens, then ones) and emits a one-cycle load strobe with the validated value.
- Sits at top level between SW/KEY pins and the day counter's load inputs.

---
 rtl/day_entry_pkg.sv | 19 +
 rtl/day_entry_if.sv | 24 ++
 rtl/key_debounce.sv | 89 ++++++++
 rtl/day_entry.sv | 115 +++++++++++
 4 files changed

// File: rtl/day_entry_pkg.sv
// Shared encodings and constants for the day-entry front end.
// Imported by the key conditioner, the entry FSM and the bus interface.
package day_entry_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTER_TENS = 2'd1,
        ENTER_ONES = 2'd2
    } entry_state_e;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] RESET_TENS = 4'd0;
    localparam logic [3:0] RESET_ONES = 4'd1;

    function automatic logic bcd_valid(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/day_entry_if.sv
// Switch/key inputs and day-load outputs of the day-entry block.
// The slave side is the entry block; the master side drives pins and consumes the load.
interface day_entry_if;

    logic       key_n;
    logic [3:0] digit_sw;
    logic [3:0] day_tens;
    logic [3:0] day_ones;
    logic       load;
    logic       entry_active;
    logic       digit_sel;
    logic       error;

    modport master (
        output key_n, digit_sw,
        input  day_tens, day_ones, load, entry_active, digit_sel, error
    );

    modport slave (
        input  key_n, digit_sw,
        output day_tens, day_ones, load, entry_active, digit_sel, error
    );

endinterface

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, counting debouncer and short/long press classifier.
// short_evt/long_evt are registered one-cycle pulses; at most one of them fires per press.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES   = 200000,
    parameter int unsigned LONG_PRESS_CYCLES = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic short_evt,
    output logic long_evt
);

    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DebW-1:0]  DebLast = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_PRESS_CYCLES);

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             long_fired_q, long_fired_d;
    logic             short_evt_q, short_evt_d;
    logic             long_evt_q, long_evt_d;
    logic             long_hit;
    logic             release_edge;

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DebLast) begin
                deb_d = ~deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        hold_cnt_d = '0;
        if (!deb_q) begin
            hold_cnt_d = (hold_cnt_q == HoldMax) ? hold_cnt_q : hold_cnt_q + 1'b1;
        end

        // Threshold is evaluated in the release cycle too, so a release at the threshold is long.
        long_hit     = (hold_cnt_q == HoldMax) && !long_fired_q;
        release_edge = deb_q && !deb_prev_q;

        long_fired_d = long_fired_q;
        if (long_hit) begin
            long_fired_d = 1'b1;
        end else if (deb_q) begin
            long_fired_d = 1'b0;
        end

        long_evt_d  = long_hit;
        short_evt_d = release_edge && !long_fired_q && !long_hit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            deb_q        <= 1'b1;
            deb_prev_q   <= 1'b1;
            deb_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            short_evt_q  <= 1'b0;
            long_evt_q   <= 1'b0;
        end else begin
            sync1_q      <= key_n;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            deb_prev_q   <= deb_q;
            deb_cnt_q    <= deb_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            long_fired_q <= long_fired_d;
            short_evt_q  <= short_evt_d;
            long_evt_q   <= long_evt_d;
        end
    end

    assign short_evt = short_evt_q;
    assign long_evt  = long_evt_q;

endmodule

// File: rtl/day_entry.sv
// Two-digit BCD day entry: short presses latch tens then ones from the switches,
// a long press aborts; a valid 01..99 value is presented with a one-cycle load strobe.
module day_entry
    import day_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 200000,
    parameter int unsigned LONG_PRESS_CYCLES = 10000000
) (
    input logic        ADC_CLK_10,
    input logic        reset,
    day_entry_if.slave bus
);

    logic short_evt;
    logic long_evt;

    key_debounce #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_key (
        .clk      (ADC_CLK_10),
        .reset    (reset),
        .key_n    (bus.key_n),
        .short_evt(short_evt),
        .long_evt (long_evt)
    );

    entry_state_e state_q, state_d;
    logic [3:0]   tens_hold_q, tens_hold_d;
    logic [3:0]   day_tens_q, day_tens_d;
    logic [3:0]   day_ones_q, day_ones_d;
    logic         load_q, load_d;
    logic         error_q, error_d;
    logic         entry_active_q, entry_active_d;
    logic         digit_sel_q, digit_sel_d;

    always_comb begin
        state_d     = state_q;
        tens_hold_d = tens_hold_q;
        day_tens_d  = day_tens_q;
        day_ones_d  = day_ones_q;
        load_d      = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (short_evt) state_d = ENTER_TENS;
            end
            ENTER_TENS: begin
                if (long_evt) begin
                    state_d = IDLE;
                end else if (short_evt) begin
                    if (!bcd_valid(bus.digit_sw)) begin
                        error_d = 1'b1;
                    end else begin
                        tens_hold_d = bus.digit_sw;
                        state_d     = ENTER_ONES;
                    end
                end
            end
            ENTER_ONES: begin
                if (long_evt) begin
                    state_d = IDLE;
                end else if (short_evt) begin
                    if (!bcd_valid(bus.digit_sw)) begin
                        error_d = 1'b1;
                    end else if (tens_hold_q == 4'd0 && bus.digit_sw == 4'd0) begin
                        // Day 00 does not exist; restart from the tens digit.
                        error_d = 1'b1;
                        state_d = ENTER_TENS;
                    end else begin
                        day_tens_d = tens_hold_q;
                        day_ones_d = bus.digit_sw;
                        load_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        entry_active_d = (state_d != IDLE);
        digit_sel_d    = (state_d == ENTER_ONES);
    end

    always_ff @(posedge ADC_CLK_10 or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            tens_hold_q    <= '0;
            day_tens_q     <= RESET_TENS;
            day_ones_q     <= RESET_ONES;
            load_q         <= 1'b0;
            error_q        <= 1'b0;
            entry_active_q <= 1'b0;
            digit_sel_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tens_hold_q    <= tens_hold_d;
            day_tens_q     <= day_tens_d;
            day_ones_q     <= day_ones_d;
            load_q         <= load_d;
            error_q        <= error_d;
            entry_active_q <= entry_active_d;
            digit_sel_q    <= digit_sel_d;
        end
    end

    assign bus.day_tens     = day_tens_q;
    assign bus.day_ones     = day_ones_q;
    assign bus.load         = load_q;
    assign bus.error        = error_q;
    assign bus.entry_active = entry_active_q;
    assign bus.digit_sel    = digit_sel_q;

endmodule
